vector_ldst_unit: RTL and testbench
===================================

# vector_ldst_unit

Multi-cycle vector memory sequencer between the address calculator and the 16-bit static RAM on the CPU's memory side. It moves one 256-bit vector, as 16 lanes of 16 bits, between consecutive SRAM words and the vector register file path.
- VLD: the unit issues 16 reads, assembles the returned words into `data_buff`, and pulses `vld_done`.
- VST: the unit captures a vector from the register file and issues 16 writes, then pulses `vst_done`.

## Interface
- `WORD_W`, default 16: SRAM word and lane width.
- `LANES`, default 16: lanes per vector. The vector width is `WORD_W*LANES` = 256.
- `clk2`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: begin an operation. Sampled only in IDLE.
- `is_store`, input, 1: 0 = VLD, 1 = VST. Sampled with `start`.
- `base_addr`, input, 16: effective address from the address calculator. Sampled with `start`.
- `vst_data`, input, 256: vector to store. Sampled with `start`. Lane i is bits `[16i+15:16i]`.
- `mem_rdata`, input, 16: SRAM read data.
- `mem_addr`, output, 16: SRAM address.
- `mem_rd`, output, 1: SRAM read strobe.
- `mem_wr`, output, 1: SRAM write strobe.
- `mem_wdata`, output, 16: SRAM write data.
- `busy`, output, 1: high in every state except IDLE.
- `vld_done`, output, 1: one-cycle pulse; `data_buff` is complete.
- `vst_done`, output, 1: one-cycle pulse; all 16 writes have been issued.
- `data_buff`, output, 256: assembled load vector. Lane i holds the word from `base+i`.

## Operation
- Internal registers:
  - latched base (16 bits), latched op (1 bit), lane counter `cnt` (4 bits), store vector register (256 bits), `data_buff` (256 bits).
- SRAM model: synchronous read. Data for an address presented with `mem_rd=1` in cycle k is valid on `mem_rdata` in cycle k+1. A write is committed at the end of the cycle in which `mem_wr=1`.
- States and transitions:
  - IDLE: if `start`=1, latch the inputs, clear `cnt`, and go to LOAD (`is_store`=0) or STORE (`is_store`=1).
  - LOAD: `mem_rd`=1 and `mem_addr`=`base+cnt`.
    - If `cnt`≥1, capture `mem_rdata` into lane `cnt-1`.
    - Increment `cnt`; when `cnt`=15, go to LDRAIN.
  - LDRAIN: `mem_rd`=0. Capture `mem_rdata` into lane 15, then go to DONE.
  - STORE: `mem_wr`=1, `mem_addr`=`base+cnt`, `mem_wdata`=store lane `cnt`.
    - Increment `cnt`; when `cnt`=15, go to DONE.
  - DONE: `vld_done`=1 if the op is a load, otherwise `vst_done`=1. Go to IDLE.
- Address arithmetic: `base+cnt` is taken modulo 2^16, so 0xFFFF+1 wraps to 0x0000. No other width extension.
- `mem_addr` and `mem_wdata` are 0 outside LOAD/STORE. `mem_rd` and `mem_wr` are never high together.
- `start` is ignored outside IDLE, including in DONE. The earliest next accept is in the IDLE cycle after DONE.
- `data_buff` holds its value between loads. During a load, lanes update progressively, so consumers read it only with `vld_done`. A store never modifies `data_buff`.
- `vst_data` and `base_addr` may change after `start`; the latched copies are used.

## Timing
- Reset value of every output is 0; all internal registers are 0; the state is IDLE.
- Reset asserted mid-operation: the unit returns to IDLE immediately (asynchronously).
  - `mem_rd`/`mem_wr` drop without waiting for a clock edge.
  - No done pulse is produced.
  - `data_buff` is cleared.
- Cycle numbering: C0 is the cycle in which `start` is sampled high in IDLE.
- VLD:
  - Reads are issued in C1–C16, with addresses `base..base+15`, one per cycle and back to back.
  - Captures happen at the ends of C2–C17.
  - `vld_done` is high in C18 only; `busy` is high in C1–C18.
- VST:
  - Writes are issued in C1–C16.
  - `vst_done` is high in C17 only; `busy` is high in C1–C17.
- Throughput: a new operation can be accepted in C19 (VLD) or C18 (VST).

## Test plan
- Reset: hold `rst`=0 with random inputs, including `start`=1 → all outputs 0. Release and wait 5 cycles with `start`=0 → `busy`=0 and no strobes.
- VLD at `base_addr`=0x0010, SRAM word a = a^0xA5A5 → `mem_rd` high C1–C16, addresses 0x0010..0x001F. `vld_done`=1 in C18 only, `data_buff` lane i = (0x0010+i)^0xA5A5. `mem_wr`=0 throughout.
- VST at `base_addr`=0x0100, `vst_data` lane i = 0x1000+i → `mem_wr` high C1–C16, addresses 0x0100..0x010F, `mem_wdata` 0x1000..0x100F. `vst_done`=1 in C17 only; read back via VLD matches; `data_buff` unchanged.
- Wrap: VLD at `base_addr`=0xFFF8 → addresses 0xFFF8..0xFFFF then 0x0000..0x0007. Lane 8 is the word from 0x0000.
- Start while busy: pulse `start` in C5 of a VLD and again in DONE → both ignored, single `vld_done`. A `start` in the following IDLE cycle is accepted.
- Reset mid-store: assert `rst`=0 during C8 of a VST → `mem_wr` drops immediately, addresses 0x0108+ are never written, and there is no `vst_done`. After release, a fresh VLD completes normally.

Source files
------------

// File: rtl/vector_ldst_unit.sv
// Vector load/store sequencer: moves one WORD_W*LANES vector between consecutive
// SRAM words and the register-file path, one lane per cycle.
module vector_ldst_unit #(
    parameter int WORD_W = 16,
    parameter int LANES  = 16
) (
    input  logic                      clk2,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      is_store,
    input  logic [15:0]               base_addr,
    input  logic [WORD_W*LANES-1:0]   vst_data,
    input  logic [WORD_W-1:0]         mem_rdata,
    output logic [15:0]               mem_addr,
    output logic                      mem_rd,
    output logic                      mem_wr,
    output logic [WORD_W-1:0]         mem_wdata,
    output logic                      busy,
    output logic                      vld_done,
    output logic                      vst_done,
    output logic [WORD_W*LANES-1:0]   data_buff
);

    localparam int VEC_W = WORD_W * LANES;
    localparam int CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LDRAIN,
        S_STORE,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [15:0]         base_q;
    logic                op_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [VEC_W-1:0]    vec_q;
    logic [VEC_W-1:0]    data_buff_q;
    logic [15:0]         mem_addr_q;
    logic                mem_rd_q;
    logic                mem_wr_q;
    logic [WORD_W-1:0]   mem_wdata_q;
    logic                busy_q;
    logic                vld_done_q;
    logic                vst_done_q;

    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    lane_prev;
    logic [15:0]         addr_d;

    assign cnt_d     = cnt_q + CNT_W'(1);
    assign lane_prev = cnt_q - CNT_W'(1);
    // Address wraps naturally at 16 bits.
    assign addr_d    = base_q + 16'(cnt_d);

    // Outputs are registered; the async reset clears them, so strobes drop
    // the moment reset asserts.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            op_q        <= 1'b0;
            cnt_q       <= '0;
            vec_q       <= '0;
            // NOTE: data_buff is a plain register bank, not a RAM, so it resets.
            data_buff_q <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            vld_done_q  <= 1'b0;
            vst_done_q  <= 1'b0;
        end else begin
            vld_done_q <= 1'b0;
            vst_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        op_q       <= is_store;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        mem_addr_q <= base_addr;
                        if (is_store) begin
                            vec_q       <= vst_data;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= vst_data[WORD_W-1:0];
                            state_q     <= S_STORE;
                        end else begin
                            mem_rd_q <= 1'b1;
                            state_q  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    // Read data lags the address by one cycle, so lane cnt-1 lands now.
                    if (cnt_q != '0) begin
                        data_buff_q[lane_prev*WORD_W +: WORD_W] <= mem_rdata;
                    end
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST) begin
                        mem_rd_q   <= 1'b0;
                        mem_addr_q <= '0;
                        state_q    <= S_LDRAIN;
                    end else begin
                        mem_addr_q <= addr_d;
                    end
                end
                S_LDRAIN: begin
                    data_buff_q[LAST*WORD_W +: WORD_W] <= mem_rdata;
                    vld_done_q <= ~op_q;
                    vst_done_q <= op_q;
                    state_q    <= S_DONE;
                end
                S_STORE: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST) begin
                        mem_wr_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        vld_done_q  <= ~op_q;
                        vst_done_q  <= op_q;
                        state_q     <= S_DONE;
                    end else begin
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= vec_q[cnt_d*WORD_W +: WORD_W];
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign vld_done  = vld_done_q;
    assign vst_done  = vst_done_q;
    assign data_buff = data_buff_q;

endmodule

// File: tb/tb_vector_ldst_unit.sv
// Scoreboard bench for vector_ldst_unit: a driver queues expected bus events from
// a word-level memory model, and a monitor pops and compares them as they appear.
module tb_vector_ldst_unit;

    logic         clk2;
    logic         rst;
    logic         start;
    logic         is_store;
    logic [15:0]  base_addr;
    logic [255:0] vst_data;
    logic [15:0]  mem_rdata;
    logic [15:0]  mem_addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [15:0]  mem_wdata;
    logic         busy;
    logic         vld_done;
    logic         vst_done;
    logic [255:0] data_buff;

    vector_ldst_unit #(.WORD_W(16), .LANES(16)) dut (
        .clk2      (clk2),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .vst_data  (vst_data),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .vld_done  (vld_done),
        .vst_done  (vst_done),
        .data_buff (data_buff)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SRAM seen by the DUT, and the bench's own view of what memory should hold.
    logic [15:0] sram    [0:65535];
    logic [15:0] ref_mem [0:65535];

    always @(posedge clk2) begin
        if (mem_wr) sram[mem_addr] <= mem_wdata;
        mem_rdata <= mem_rd ? sram[mem_addr] : 16'($urandom);
    end

    typedef enum logic [1:0] {EV_RD, EV_WR, EV_VLD, EV_VST} ev_e;
    typedef struct {
        ev_e          kind;
        logic [15:0]  addr;
        logic [15:0]  data;
        logic [255:0] vec;
    } ev_t;

    ev_t          sb_q[$];
    logic [255:0] last_buff;

    task automatic expect_ev(input ev_e kind, input logic [15:0] addr,
                             input logic [15:0] data, input logic [255:0] vec);
        ev_t e;
        if (sb_q.size() == 0) begin
            check("unexpected_event", {254'd0, kind}, 256'hF);
        end else begin
            e = sb_q.pop_front();
            check("event_kind", {254'd0, kind}, {254'd0, e.kind});
            if (kind == EV_RD || kind == EV_WR) check("mem_addr", addr, e.addr);
            if (kind == EV_WR) check("mem_wdata", data, e.data);
            if (kind == EV_VLD) check("data_buff", vec, e.vec);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk2) begin
        check("rd_wr_exclusive", mem_rd & mem_wr, 1'b0);
        if (!mem_rd && !mem_wr) check("idle_bus_zero", {mem_addr, mem_wdata}, 32'd0);
        if (mem_rd)   expect_ev(EV_RD, mem_addr, 16'd0, 256'd0);
        if (mem_wr)   expect_ev(EV_WR, mem_addr, mem_wdata, 256'd0);
        if (vld_done) expect_ev(EV_VLD, 16'd0, 16'd0, data_buff);
        if (vst_done) expect_ev(EV_VST, 16'd0, 16'd0, 256'd0);
    end

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Issue one operation; called at 1 time unit after a rising edge while idle.
    task automatic run_op(input bit st, input logic [15:0] base, input logic [255:0] vec,
                          input bit poke);
        logic [255:0] exp_vec;
        logic [15:0]  a;
        ev_t          e;
        int           done_c;
        int           exp_done;
        bit           ok_strobe;
        bit           ok_busy;
        exp_vec = '0;
        for (int i = 0; i < 16; i++) begin
            a = base + 16'(i);
            e.addr = a;
            e.vec  = '0;
            if (st) begin
                e.kind = EV_WR;
                e.data = vec[i*16 +: 16];
                ref_mem[a] = vec[i*16 +: 16];
            end else begin
                e.kind = EV_RD;
                e.data = '0;
                exp_vec[i*16 +: 16] = ref_mem[a];
            end
            sb_q.push_back(e);
        end
        e.kind = st ? EV_VST : EV_VLD;
        e.addr = '0;
        e.data = '0;
        e.vec  = exp_vec;
        sb_q.push_back(e);
        if (!st) last_buff = exp_vec;
        exp_done = st ? 17 : 18;

        start     = 1'b1;
        is_store  = st;
        base_addr = base;
        vst_data  = vec;
        @(posedge clk2); #1;
        start     = 1'b0;
        is_store  = 1'($urandom);
        base_addr = 16'($urandom);
        vst_data  = rand_vec();

        done_c    = 0;
        ok_strobe = 1'b1;
        ok_busy   = 1'b1;
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            start = poke && (c == 5 || c == exp_done);
            @(negedge clk2);
            if (mem_rd !== (!st && c <= 16)) ok_strobe = 1'b0;
            if (mem_wr !== (st && c <= 16))  ok_strobe = 1'b0;
            if (busy !== 1'b1)               ok_busy   = 1'b0;
            if (vld_done || vst_done) done_c = c;
            @(posedge clk2); #1;
        end
        start = 1'b0;
        check("done_cycle", done_c, exp_done);
        check("strobe_window", ok_strobe, 1'b1);
        check("busy_window", ok_busy, 1'b1);
        check("idle_after_done", busy, 1'b0);
        if (st) check("store_keeps_buff", data_buff, last_buff);
    endtask

    task automatic reset_mid_store();
        logic [255:0] vec;
        ev_t          e;
        int           bad;
        for (int i = 0; i < 16; i++) vec[i*16 +: 16] = 16'hBEE0 + 16'(i);
        for (int i = 0; i < 7; i++) begin
            e.kind = EV_WR;
            e.addr = 16'h0100 + 16'(i);
            e.data = vec[i*16 +: 16];
            e.vec  = '0;
            ref_mem[e.addr] = e.data;
            sb_q.push_back(e);
        end
        start     = 1'b1;
        is_store  = 1'b1;
        base_addr = 16'h0100;
        vst_data  = vec;
        @(posedge clk2); #1;
        start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(posedge clk2); #1;
        end
        #1 rst = 1'b0;
        #1;
        check("reset_drops_wr", {mem_wr, mem_rd, busy}, 3'b000);
        check("reset_bus_zero", {mem_addr, mem_wdata}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk2);
            check("reset_no_done", {vld_done, vst_done}, 2'b00);
        end
        check("reset_clears_buff", data_buff, 256'd0);
        last_buff = '0;
        @(posedge clk2); #1;
        rst = 1'b1;
        check("reset_sb_drained", sb_q.size(), 0);
        bad = 0;
        for (int i = 7; i < 16; i++) begin
            if (sram[16'h0100 + 16'(i)] !== ref_mem[16'h0100 + 16'(i)]) bad++;
        end
        check("reset_no_late_writes", bad, 0);
    endtask

    initial begin
        logic [255:0] v;
        for (int a = 0; a < 65536; a++) begin
            sram[a]    = 16'(a) ^ 16'hA5A5;
            ref_mem[a] = 16'(a) ^ 16'hA5A5;
        end
        last_buff = '0;

        // Reset held with random inputs and start high.
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            start     = 1'b1;
            is_store  = 1'($urandom);
            base_addr = 16'($urandom);
            vst_data  = rand_vec();
            @(negedge clk2);
            check("reset_outputs", {mem_addr, mem_rd, mem_wr, mem_wdata, busy, vld_done,
                                    vst_done}, 37'd0);
            check("reset_data_buff", data_buff, 256'd0);
        end
        @(posedge clk2); #1;
        rst   = 1'b1;
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk2);
            check("post_reset_idle", {busy, mem_rd, mem_wr}, 3'b000);
        end
        @(posedge clk2); #1;

        // Directed: load, store + readback, wrap, start while busy.
        run_op(1'b0, 16'h0010, 256'd0, 1'b0);
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'h1000 + 16'(i);
        run_op(1'b1, 16'h0100, v, 1'b0);
        run_op(1'b0, 16'h0100, 256'd0, 1'b0);
        run_op(1'b0, 16'hFFF8, 256'd0, 1'b0);
        check("wrap_lane8", data_buff[143:128], ref_mem[0]);
        run_op(1'b0, 16'h0040, 256'd0, 1'b1);
        run_op(1'b1, 16'h0200, rand_vec(), 1'b1);
        run_op(1'b0, 16'h0200, 256'd0, 1'b0);

        // Reset in the middle of a store, then a fresh load over the same range.
        reset_mid_store();
        run_op(1'b0, 16'h0100, 256'd0, 1'b0);

        // Random mix over a small window so loads revisit stored data.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] b;
            b = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                             : 16'h0300 + 16'($urandom_range(0, 63));
            run_op(1'($urandom), b, rand_vec(), 1'($urandom));
        end

        repeat (3) @(posedge clk2);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
